prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a stream of 16-bit words through a small FIFO and writes
// them into a 4096x16 memory at consecutive addresses starting at start_addr.
// Each word takes three cycles to store (LOAD, WRITE, INCR). The session ends after
// the word flagged in_last. The address register wraps from 0xFFF to 0x000; a wrap
// before the last word sets the sticky wrap_err flag.
module prog_loader #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] start_addr,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_write,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic [12:0] count,
    output logic        wrap_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_ZERO = {OW{1'b0}};
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_INCR  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [OW-1:0] occ_r;
    logic [OW-1:0] occ_nxt_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [16:0]   fifo_mem_r [DEPTH];
    logic [11:0]   ar_r;
    logic [15:0]   data_r;
    logic          last_r;
    logic [12:0]   count_r;
    logic          wrap_err_r;
    logic          in_ready_r;
    logic          mem_write_r;
    logic          busy_r;
    logic          done_r;
    logic          start_s;
    logic          push_s;
    logic          pop_s;
    logic          next_active_s;

    // A session only starts from IDLE; start is ignored everywhere else.
    assign start_s = (state_r == ST_IDLE) && start;
    assign push_s  = in_valid && in_ready_r;
    assign pop_s   = (state_r == ST_LOAD) && (occ_r != OCC_ZERO);

    // Next-state decode of the load sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_LOAD;
                else       state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (occ_r != OCC_ZERO) state_nxt_s = ST_WRITE;
                else                   state_nxt_s = ST_LOAD;
            end
            ST_WRITE: state_nxt_s = ST_INCR;
            ST_INCR: begin
                if (last_r) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_LOAD;
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Next FIFO occupancy: flush on start, simultaneous push/pop leaves it unchanged.
    always_comb begin
        occ_nxt_s = occ_r;
        if (start_s) begin
            occ_nxt_s = OCC_ZERO;
        end else if (push_s && !pop_s) begin
            occ_nxt_s = occ_r + OCC_ONE;
        end else if (!push_s && pop_s) begin
            occ_nxt_s = occ_r - OCC_ONE;
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    assign next_active_s = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_WRITE) ||
                           (state_nxt_s == ST_INCR);

    // Sequencer state, address/data registers, status flags and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            occ_r       <= OCC_ZERO;
            ar_r        <= 12'h000;
            data_r      <= 16'h0000;
            last_r      <= 1'b0;
            count_r     <= 13'h0000;
            wrap_err_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            mem_write_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            occ_r       <= occ_nxt_s;
            // in_ready follows the registered occupancy of the coming cycle.
            in_ready_r  <= next_active_s && (occ_nxt_s < OCC_FULL);
            mem_write_r <= (state_nxt_s == ST_WRITE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ar_r       <= start_addr;
                        count_r    <= 13'h0000;
                        wrap_err_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (pop_s) begin
                        data_r <= fifo_mem_r[rd_ptr_r][15:0];
                        last_r <= fifo_mem_r[rd_ptr_r][16];
                    end
                end
                ST_WRITE: begin
                    if (count_r != 13'h1FFF) count_r <= count_r + 13'h0001;
                end
                ST_INCR: begin
                    ar_r <= ar_r + 12'h001;
                    if ((ar_r == 12'hFFF) && !last_r) wrap_err_r <= 1'b1;
                end
                ST_DONE: begin
                    last_r <= 1'b0;
                end
                default: begin
                    last_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage and pointers; a new session discards anything left over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 17'h00000;
            end
        end else if (start_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {in_last, in_data};
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Reset is sampled at the clock edge, so outputs are held at their reset
    // values while rst_n is low; this keeps an aborted WRITE from strobing.
    assign in_ready  = rst_n && in_ready_r;
    assign mem_write = rst_n && mem_write_r;
    assign busy      = rst_n && busy_r;
    assign done      = rst_n && done_r;
    assign wrap_err  = rst_n && wrap_err_r;
    assign mem_addr  = rst_n ? ar_r    : 12'h000;
    assign mem_data  = rst_n ? data_r  : 16'h0000;
    assign count     = rst_n ? count_r : 13'h0000;

endmodule
